// File: rtl/mskg16_pkg.sv
// mskg16_pkg: shared types and helpers for the masked G(16) share-recombination slice.
// Holds the unmasking FSM state encoding, the nibble type and the share-counter width helper.
package mskg16_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFRESH = 2'd1,
    ACC     = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [3:0] nibble_t;

  // Share counter width: max(1, clog2(d)), so d=1 and d=2 still get a 1-bit counter.
  function automatic int cnt_width(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/mskg16_share_refresh.sv
// mskg16_share_refresh: one-register-stage refresh of a d-share nibble sharing.
// Shares 0..d-2 each absorb one fresh random nibble and the last share absorbs the XOR
// of all of them, so the encoded nibble is unchanged while every share is re-randomised.
// Only instantiated when MSKG16_UNMASK_REFRESH_EN is defined.
module mskg16_share_refresh
  import mskg16_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [4*d-1:0]   shares_in,
  input  logic [4*(d-1)-1:0] rnd,
  output logic [4*d-1:0]   shares_out
);

  nibble_t        mask_sum;
  logic [4*d-1:0] refreshed;

  // Mask every share but the last with its own nibble; the last share cancels the sum.
  always_comb begin
    mask_sum  = '0;
    refreshed = shares_in;
    for (int j = 0; j < d - 1; j++) begin
      mask_sum               = mask_sum ^ rnd[4*j +: 4];
      refreshed[4*j +: 4]    = shares_in[4*j +: 4] ^ rnd[4*j +: 4];
    end
    refreshed[4*(d-1) +: 4] = shares_in[4*(d-1) +: 4] ^ mask_sum;
  end

  // Register the refreshed sharing when the parent FSM sits in its refresh cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shares_out <= '0;
    end else if (en) begin
      shares_out <= refreshed;
    end
  end

endmodule

// File: rtl/mskg16_unmask_seq.sv
// mskg16_unmask_seq: sequential recombination of a d-share G(16) sharing into a plain nibble.
// One captured share is folded into the accumulator per cycle so no two shares ever meet
// in the same combinational cone straight from the inputs.
// Optional feature: define MSKG16_UNMASK_REFRESH_EN to add the rnd port and a one-cycle
// share refresh before recombination (requires d >= 2). Default share count: DEFAULTSHARES.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module mskg16_unmask_seq
  import mskg16_pkg::*;
#(
  parameter int d = `DEFAULTSHARES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [d-1:0] in0,
  input  logic [d-1:0] in1,
  input  logic [d-1:0] in2,
  input  logic [d-1:0] in3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_data
`ifdef MSKG16_UNMASK_REFRESH_EN
  ,
  input  logic [4*(d-1)-1:0] rnd
`endif
);

  localparam int            CW   = cnt_width(d);
  localparam logic [CW-1:0] LAST = CW'(d - 1);

  state_t         state_q, state_d;
  logic [4*d-1:0] share_q;
  logic [4*d-1:0] captured;
  logic [4*d-1:0] acc_src;
  nibble_t        acc_q;
  nibble_t        cur_share;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  nibble_t        out_data_q;
  logic           accept;
  logic           last_share;

`ifdef MSKG16_UNMASK_REFRESH_EN
  localparam state_t FIRST = REFRESH;
  logic           refresh_en;
  logic [4*d-1:0] refreshed_q;

  if (d < 2) begin : g_bad_share_count
    $error("mskg16_unmask_seq: share refresh needs d >= 2");
  end

  mskg16_share_refresh #(
    .d (d)
  ) u_refresh (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (refresh_en),
    .shares_in  (share_q),
    .rnd        (rnd),
    .shares_out (refreshed_q)
  );

  assign acc_src = refreshed_q;
`else
  localparam state_t FIRST = ACC;
  assign acc_src = share_q;
`endif

  // Regroup the bit-per-share inputs into one nibble per share: share j = {in3[j],in2[j],in1[j],in0[j]}.
  always_comb begin
    captured = '0;
    for (int j = 0; j < d; j++) begin
      captured[4*j +: 4] = {in3[j], in2[j], in1[j], in0[j]};
    end
  end

  // Select the single captured share addressed by the counter for this cycle's fold.
  always_comb begin
    cur_share = '0;
    for (int j = 0; j < d; j++) begin
      if (cnt_q == CW'(j)) begin
        cur_share = acc_src[4*j +: 4];
      end
    end
  end

  // Next-state logic: accept in IDLE, optional refresh, fold d shares, hold until consumed.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_share = 1'b0;
`ifdef MSKG16_UNMASK_REFRESH_EN
    refresh_en = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = FIRST;
        end
      end
`ifdef MSKG16_UNMASK_REFRESH_EN
      REFRESH: begin
        refresh_en = 1'b1;
        state_d    = ACC;
      end
`endif
      ACC: begin
        if (cnt_q == LAST) begin
          last_share = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; in_ready stays low out of reset until the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Datapath: capture on accept, fold one share per ACC cycle, latch the result on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else if (accept) begin
      share_q <= captured;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == ACC) begin
      acc_q <= acc_q ^ cur_share;
      cnt_q <= cnt_q + 1'b1;
      if (last_share) begin
        out_data_q <= acc_q ^ cur_share;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mskg16_unmask_seq.sv
// tb_mskg16_unmask_seq: directed self-checking bench for mskg16_unmask_seq.
// Two instances (d=2 and d=3) share clock, reset, out_ready and the share inputs;
// each has its own in_valid and 'sel' picks which one a test drives and observes.
// Honours MSKG16_UNMASK_REFRESH_EN (random rnd every cycle, one extra cycle of latency).
module tb_mskg16_unmask_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       out_ready = 1'b0;
  logic [2:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic       in_valid2 = 1'b0, in_valid3 = 1'b0;
  logic       in_ready2, in_ready3, out_valid2, out_valid3;
  logic [3:0] out_data2, out_data3;
  bit         sel = 1'b0;
  int         vec_count = 0;
  int         miss_count = 0;
  int         cyc = 0;

`ifdef MSKG16_UNMASK_REFRESH_EN
  localparam int EXTRA = 1;
  logic [7:0] rnd = '0;
  // Fresh refresh randomness every cycle, changed away from the active edge.
  always @(negedge clk) rnd = 8'($urandom);
`else
  localparam int EXTRA = 0;
`endif

  // Free-running clock and edge counter used to measure accept spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mskg16_unmask_seq #(.d(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in0       (in0[1:0]),
    .in1       (in1[1:0]),
    .in2       (in2[1:0]),
    .in3       (in3[1:0]),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2)
`ifdef MSKG16_UNMASK_REFRESH_EN
    ,
    .rnd       (rnd[3:0])
`endif
  );

  mskg16_unmask_seq #(.d(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_data  (out_data3)
`ifdef MSKG16_UNMASK_REFRESH_EN
    ,
    .rnd       (rnd)
`endif
  );

  function automatic logic m_in_ready();
    return sel ? in_ready3 : in_ready2;
  endfunction

  function automatic logic m_out_valid();
    return sel ? out_valid3 : out_valid2;
  endfunction

  function automatic logic [3:0] m_out_data();
    return sel ? out_data3 : out_data2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setValid(input logic v);
    if (sel) in_valid3 = v;
    else     in_valid2 = v;
  endtask

  // Drive one sharing on the selected instance and return just after its accept edge.
  task automatic applyStimulus(input bit s, input logic [2:0] a0, input logic [2:0] a1,
                               input logic [2:0] a2, input logic [2:0] a3, input bit keep);
    int n;
    sel = s;
    in0 = a0; in1 = a1; in2 = a2; in3 = a3;
    setValid(1'b1);
    n = 0;
    while (!m_in_ready() && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", m_in_ready(), 1);
    tick();
    if (!keep) setValid(1'b0);
  endtask

  // Count cycles from the accept edge until out_valid shows, bounded.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!m_out_valid() && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    int  c1, c2, nres;
    bit  seen, will_acc;
    logic [3:0] res [2];

    // Reset values on both instances.
    #2 rst_n = 1'b0;
    #10;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      checkOutput("rst_in_ready", m_in_ready(), 0);
      checkOutput("rst_out_valid", m_out_valid(), 0);
      checkOutput("rst_out_data", m_out_data(), 4'h0);
    end
    rst_n = 1'b1;
    tick();
    sel = 1'b0;
    checkOutput("rst_release_ready2", m_in_ready(), 1);
    sel = 1'b1;
    checkOutput("rst_release_ready3", m_in_ready(), 1);

    // Basic d=2: shares 3 and 5 recombine to 6.
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'b011, 3'b001, 3'b010, 3'b000, 1'b0);
    checkOutput("basic_in_ready_low", m_in_ready(), 0);
    waitResult(lat);
    checkOutput("basic_latency", lat, 2 + EXTRA);
    checkOutput("basic_data", m_out_data(), 4'h6);
    tick();
    checkOutput("basic_valid_clear", m_out_valid(), 0);
    checkOutput("basic_ready_back", m_in_ready(), 1);

    // Three shares of F recombine to F.
    applyStimulus(1'b1, 3'b111, 3'b111, 3'b111, 3'b111, 1'b0);
    waitResult(lat);
    checkOutput("three_latency", lat, 3 + EXTRA);
    checkOutput("three_data", m_out_data(), 4'hF);
    tick();
    checkOutput("three_ready_back", m_in_ready(), 1);

    // Backpressure in DONE with a competing in_valid.
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'b011, 3'b001, 3'b010, 3'b000, 1'b0);
    waitResult(lat);
    checkOutput("bp_latency", lat, 2 + EXTRA);
    in0 = 3'b001; in1 = 3'b000; in2 = 3'b011; in3 = 3'b010;
    in_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid_hold", m_out_valid(), 1);
      checkOutput("bp_data_hold", m_out_data(), 4'h6);
      checkOutput("bp_ready_low", m_in_ready(), 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_valid_clear", m_out_valid(), 0);
    checkOutput("bp_ready_back", m_in_ready(), 1);
    in_valid2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_out_valid()) seen = 1'b1;
    end
    checkOutput("bp_no_spurious", seen, 0);

    // Reset one cycle after accept on d=3 aborts the operation.
    applyStimulus(1'b1, 3'b111, 3'b111, 3'b111, 3'b111, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", m_out_valid(), 0);
    checkOutput("abort_out_data", m_out_data(), 4'h0);
    checkOutput("abort_in_ready", m_in_ready(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abort_ready_release", m_in_ready(), 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_out_valid()) seen = 1'b1;
    end
    checkOutput("abort_no_stale", seen, 0);

    // Back-to-back on d=2 with in_valid held: 3 then C, accepts d+2 apart.
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
    c1 = cyc;
    c2 = 0;
    in0 = 3'b000; in1 = 3'b000; in2 = 3'b010; in3 = 3'b010;
    nres = 0;
    res[0] = '0;
    res[1] = '0;
    for (int i = 0; i < 30 && nres < 2; i++) begin
      will_acc = m_in_ready() && in_valid2;
      tick();
      if (will_acc) begin
        c2 = cyc;
        in_valid2 = 1'b0;
      end
      if (m_out_valid()) begin
        res[nres] = m_out_data();
        nres++;
      end
    end
    checkOutput("b2b_count", nres, 2);
    checkOutput("b2b_first", res[0], 4'h3);
    checkOutput("b2b_second", res[1], 4'hC);
    checkOutput("b2b_spacing", c2 - c1, 4 + EXTRA);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/mskg16_unmask_seq.md
# mskg16_unmask_seq

Sequential share-recombination (unmasking) unit for G(16) sharings, the decoding end of the masked G(16) datapath. It accepts one d-share sharing of a 4-bit field element in the bit-per-share bundle layout used by the masked G(16) gadgets and folds the shares together one per cycle. It returns the plain nibble over a valid/ready handshake. It sits at the boundary of the masked core, after the last masked multiplier or inverter stage, and feeds the unmasked output or the test harness.

## Interface
- d, default `DEFAULTSHARES (2): number of shares per bit.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  sharing on in0..in3 is valid.
- in_ready  out  1  block can accept a sharing (registered).
- in0, in1, in2, in3  in  d each  sharing of bits 0..3; bit i of each is share i.
- out_valid  out  1  out_data holds a result (registered).
- out_ready  in  1  consumer accepts out_data.
- out_data  out  4  recombined nibble {b3,b2,b1,b0}.
- rnd  in  4*(d-1)  refresh randomness, fresh each cycle; present only with MSKG16_UNMASK_REFRESH_EN.

## Operation
- FSM states: IDLE, REFRESH (macro only), ACC, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, capture in0..in3 into a 4*d share register, clear acc[3:0] and cnt.
  - Go to REFRESH if the macro is defined, otherwise go to ACC. in_ready drops on the same edge.
- REFRESH: exactly one cycle.
  - Share j (j<d-1) ^= rnd[4j +: 4].
  - Share d-1 ^= XOR of all d-1 rnd nibbles.
  - This preserves the encoded value. Go to ACC.
- ACC: each cycle, acc ^= share[cnt] = {in3[cnt],in2[cnt],in1[cnt],in0[cnt]} (captured copy), then cnt++.
  - When cnt==d-1, load out_data with the final XOR, set out_valid, and go to DONE.
- DONE: hold out_data and out_valid.
  - On out_ready, clear out_valid, set in_ready, and go to IDLE.
- No pass-through.
  - in_valid is ignored outside IDLE, including in the DONE cycle in which out_ready is high.
  - The next accept is possible no earlier than the edge after returning to IDLE.
- Inputs are never combined combinationally. Only one captured share enters the XOR per cycle, which limits glitch coupling between shares.
- cnt width is max(1, clog2(d)). There is no wrap: cnt is cleared on accept.
- d=1 is legal without the macro, giving one ACC cycle. With the macro, d>=2 is required and d<2 is an elaboration error.

## Timing
- Reset (async assert, synchronous release effect):
  - state=IDLE, in_ready=0, out_valid=0, out_data=4'h0, acc=0, cnt=0, share register=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Latency: accept at edge k gives out_valid high after edge k+d (k+d+1 with the macro).
- Throughput: one sharing per d+2 cycles (d+3 with the macro) when out_ready is held high.
- rst_n low mid-operation aborts immediately. The partial result is discarded and no out_valid pulse is produced.
- out_data is stable while out_valid=1 and out_ready=0.

## Configuration
- MSKG16_UNMASK_REFRESH_EN defined:
  - The rnd port and the REFRESH state exist.
  - Shares are re-randomised before recombination.
  - Latency +1.
- MSKG16_UNMASK_REFRESH_EN not defined:
  - No rnd port and no REFRESH state.
  - Latency d.

## Structure
- Package mskg16_pkg:
  - state enum (IDLE, REFRESH, ACC, DONE).
  - nibble typedef logic [3:0].
  - cnt-width function max(1, clog2(d)).
- Sub-module mskg16_share_refresh (d-share nibble refresh, one register stage). Instantiated only under the macro.

## Test plan
- Basic accept and result: d=2, in0=2'b11, in1=2'b01, in2=2'b10, in3=2'b00, out_ready=1. Required:
  - in_ready falls after the accept edge.
  - out_valid rises 2 cycles after accept with out_data=4'h6.
  - in_ready returns 1 the cycle after the out handshake.
- Three shares: d=3, all inputs 3'b111. Required: out_data=4'hF, valid 3 cycles after accept.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE. Required: out_data and out_valid stable and in_ready=0 throughout.
  - Drive a new in_valid during those cycles. Required: not accepted.
- Reset mid-ACC: d=3, pull rst_n low 1 cycle after accept. Required:
  - out_valid=0, out_data=0 immediately.
  - in_ready=1 one edge after release.
  - No stale result afterwards.
- Back-to-back with in_valid held high and sharings of 4'h3 then 4'hC (d=2). Required:
  - Results 4'h3 then 4'hC in order.
  - Accepts exactly d+2 cycles apart.
- Macro defined (d=2), random rnd every cycle, the same stimulus as the basic test. Required: out_data=4'h6 with latency 3.
